vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
// - Shares port A of the 32K x 8 dual-port video RAM between two requesters:
//   the Z80 host-bus interface (cpu_*) and an auxiliary engine (aux_*, e.g. clear/fill).
// - Port B stays dedicated to the video scan-out path.
// - Issues at most one access per clock.
// - Tracks in-flight reads through the pipelined BRAM latency and returns read data
//   to the requester that issued the read.
// PARAMETERS
// - ADDR_W      15  video RAM address width (32K x 8)
// - DATA_W      8   data width
// - RD_LAT      2   clocks from access cycle to valid ram_douta (output register enabled)
// - STARVE_MAX  4   consecutive cycles aux may be denied while requesting before it is
//                   forced to win (range 1..15)
// PORTS
// - clk          in   1       system clock; RAM port A is clocked by the same clk
// - reset        in   1       synchronous, active-high reset
// - cpu_req      in   1       host access request; held until cpu_ack
// - cpu_we       in   1       1 = write, 0 = read
// - cpu_addr     in   ADDR_W  host address
// - cpu_wdata    in   DATA_W  host write data
// - cpu_ack      out  1       access accepted this cycle
// - cpu_rvalid   out  1       rd_data holds host read data this cycle
// - aux_req/aux_we/aux_addr/aux_wdata/aux_ack/aux_rvalid
//                             same meaning and widths as the cpu_* ports, for the aux requester
// - rd_data      out  DATA_W  read data, shared by both requesters, qualified by *_rvalid
// - ram_ada      out  ADDR_W  port A address
// - ram_dina     out  DATA_W  port A write data
// - ram_wrea     out  1       port A write enable
// - ram_cea      out  1       port A clock enable
// - ram_ocea     out  1       port A output register enable
// - ram_reseta   out  1       port A output reset
// - ram_douta    in   DATA_W  port A read data
// BEHAVIOUR
// - Grant is combinational from the current requests and the registered starvation counter.
//   - Only cpu_req: grant cpu. Only aux_req: grant aux. Neither: idle.
//   - Both requesting and starve_cnt < STARVE_MAX: grant cpu, starve_cnt += 1.
//   - Both requesting and starve_cnt == STARVE_MAX: grant aux.
//   - starve_cnt clears to 0 on any aux grant, and whenever aux_req is low.
// - Grant cycle N:
//   - the winner's *_ack = 1;
//   - ram_cea = 1; ram_ada, ram_dina and ram_wrea are muxed combinationally from the winner;
//   - the RAM samples at the end of cycle N.
// - Idle cycle: ram_cea = 0, ram_wrea = 0, ram_ada/ram_dina = 0.
// - Requester rules:
//   - a requester changes or drops its request only after the cycle in which its ack was 1;
//   - back-to-back accesses every cycle are legal.
// - Read return:
//   - a read granted in cycle N gives *_rvalid = 1 in cycle N+RD_LAT, owner-tagged;
//   - rd_data = ram_douta in that cycle.
//   - Writes never produce rvalid.
//   - Reads are pipelined: up to RD_LAT reads can be in flight, returned strictly in order.
// - ram_ocea = 1 constantly; ram_reseta = reset.
// - Write collisions with port B are not arbitrated here (port B is read-only).
// - Reset, including mid-operation:
//   - in the reset cycle, both acks are 0 and ram_cea/ram_wrea are 0;
//   - all tag-pipeline valids and starve_cnt clear, so in-flight reads are dropped
//     with no rvalid;
//   - the first grant can occur in the first cycle after reset deasserts.
// - Output reset values: acks 0, rvalids 0, ram_cea 0, ram_wrea 0, ram_ada 0,
//   ram_dina 0, ram_ocea 1, ram_reseta 1.
// - *_rvalid is never 1 for both requesters in the same cycle.
// STRUCTURE
// - Package vram_pkg:
//   - VRAM_ADDR_W = 15, VRAM_DATA_W = 8, VRAM_RD_LAT = 2;
//   - typedef vram_owner_t {OWN_CPU, OWN_AUX}.
// - Sub-module vram_rd_tag_pipe:
//   - RD_LAT-deep shift register of {valid, owner};
//   - sync-reset clears every valid;
//   - outputs cpu_rvalid/aux_rvalid from the last stage.
// - Top level contains the grant logic, starve counter and port-A mux only.
// TESTING
// - Reset, then cpu write 0x1234 <= 0xA5, then cpu read 0x1234
//   -> cpu_ack on each grant cycle; cpu_rvalid exactly 2 clocks after the read ack,
//   rd_data = 0xA5; aux_rvalid stays 0.
// - cpu_req and aux_req held continuously (reads)
//   -> grant pattern cpu,cpu,cpu,cpu,aux repeating; aux gets 1 ack per 5 cycles.
// - aux streams reads of 0x0000..0x0003 every cycle, cpu idle
//   -> 4 consecutive acks; aux_rvalid for 4 consecutive cycles, data in address order.
// - Interleaved cpu read 0x0010 (data 0x11) and aux read 0x0020 (data 0x22)
//   in adjacent cycles -> cpu_rvalid with 0x11, then aux_rvalid with 0x22 on the
//   next cycle; never both rvalids in one cycle.
// - reset asserted 1 cycle after a cpu read ack
//   -> no cpu_rvalid ever appears for that read; starve_cnt = 0; first post-reset grant
//   goes to cpu if both requesters are requesting.
// - aux write 0x7FFF <= 0x3C followed by cpu read 0x7FFF
//   -> rd_data = 0x3C; ram_wrea = 1 only in the aux write cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// Purpose : shared constants and types for the video-RAM port-A arbiter.
// Latency : n/a (package only).
// Backpres: n/a (package only).
package vram_pkg;

    localparam int VRAM_ADDR_W   = 15;
    localparam int VRAM_DATA_W   = 8;
    localparam int VRAM_RD_LAT   = 2;
    // Wide enough for the full 1..15 starvation-limit range.
    localparam int VRAM_STARVE_W = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } vram_owner_t;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_AUX  = 2'd2
    } vram_grant_t;

    // One stage of the in-flight read tracker.
    typedef struct packed {
        logic        vld;
        vram_owner_t owner;
    } vram_tag_t;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Purpose : bundles both requester channels, the shared read return and RAM port A.
// Latency : n/a (wiring only).
// Backpres: requests are held by the requester until its ack.
// Ports   : cpu_* / aux_* request channels with ack and rvalid, shared rd_data,
//           ram_* port-A controls and ram_douta read data.
//           slave modport = arbiter side, master modport = requesters + RAM side.
interface vram_port_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ack;
    logic              aux_rvalid;

    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] ram_ada;
    logic [DATA_W-1:0] ram_dina;
    logic              ram_wrea;
    logic              ram_cea;
    logic              ram_ocea;
    logic              ram_reseta;
    logic [DATA_W-1:0] ram_douta;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        input  ram_douta,
        output cpu_ack, cpu_rvalid, aux_ack, aux_rvalid, rd_data,
        output ram_ada, ram_dina, ram_wrea, ram_cea, ram_ocea, ram_reseta
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        output ram_douta,
        input  cpu_ack, cpu_rvalid, aux_ack, aux_rvalid, rd_data,
        input  ram_ada, ram_dina, ram_wrea, ram_cea, ram_ocea, ram_reseta
    );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Purpose : follows each issued read through the BRAM pipeline and tags its return.
// Latency : rvalid appears RD_LAT clocks after the issue cycle.
// Backpres: none; one tag enters per clock, returns cannot be stalled.
// Ports   : clk, reset (sync, active-high); issue_vld/issue_owner from the grant
//           cycle; cpu_rvalid/aux_rvalid from the last stage.
module vram_rd_tag_pipe
    import vram_pkg::*;
#(
    parameter int RD_LAT = VRAM_RD_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_vld,
    input  vram_owner_t issue_owner,
    output logic        cpu_rvalid,
    output logic        aux_rvalid
);

    vram_tag_t pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: issue_vld, owner: issue_owner};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Masked during reset so a read that happens to land in the reset cycle
    // is dropped along with everything else still in flight.
    assign cpu_rvalid = pipe[RD_LAT-1].vld && (pipe[RD_LAT-1].owner == OWN_CPU) && !reset;
    assign aux_rvalid = pipe[RD_LAT-1].vld && (pipe[RD_LAT-1].owner == OWN_AUX) && !reset;

endmodule

// File: rtl/vram_port_arbiter.sv
// Purpose : shares video-RAM port A between the host CPU and the aux engine.
// Latency : ack combinational in the grant cycle; read data RD_LAT clocks later.
// Backpres: loser keeps its request up; aux wins after STARVE_MAX denied cycles.
// Ports   : clk, reset (sync, active-high); bus = vram_port_arbiter_if.slave
//           carrying both request channels, rd_data and the port-A controls.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int RD_LAT     = VRAM_RD_LAT,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vram_port_arbiter_if.slave   bus
);

    localparam logic [VRAM_STARVE_W-1:0] STARVE_LIM = VRAM_STARVE_W'(STARVE_MAX);

    vram_grant_t               grant;
    logic [VRAM_STARVE_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0]         mux_addr;
    logic [DATA_W-1:0]         mux_wdata;
    logic                      mux_we;
    logic                      issue_vld;
    vram_owner_t               issue_owner;

    // Grant: cpu has priority, except once aux has been denied STARVE_MAX
    // times in a row while continuously requesting.
    always_comb begin
        grant = GNT_IDLE;
        if (!reset) begin
            if (bus.cpu_req && bus.aux_req) begin
                grant = (starve_cnt >= STARVE_LIM) ? GNT_AUX : GNT_CPU;
            end else if (bus.cpu_req) begin
                grant = GNT_CPU;
            end else if (bus.aux_req) begin
                grant = GNT_AUX;
            end
        end
    end

    // Counts only cycles where aux asked and cpu took the port.
    always_ff @(posedge clk) begin
        if (reset || !bus.aux_req || grant == GNT_AUX) begin
            starve_cnt <= '0;
        end else if (grant == GNT_CPU) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        mux_addr    = '0;
        mux_wdata   = '0;
        mux_we      = 1'b0;
        issue_owner = OWN_CPU;
        case (grant)
            GNT_CPU: begin
                mux_addr  = bus.cpu_addr;
                mux_wdata = bus.cpu_wdata;
                mux_we    = bus.cpu_we;
            end
            GNT_AUX: begin
                mux_addr    = bus.aux_addr;
                mux_wdata   = bus.aux_wdata;
                mux_we      = bus.aux_we;
                issue_owner = OWN_AUX;
            end
            default: ;
        endcase
    end

    assign issue_vld = (grant != GNT_IDLE) && !mux_we;

    assign bus.cpu_ack    = (grant == GNT_CPU);
    assign bus.aux_ack    = (grant == GNT_AUX);
    assign bus.ram_cea    = (grant != GNT_IDLE);
    assign bus.ram_wrea   = mux_we;
    assign bus.ram_ada    = mux_addr;
    assign bus.ram_dina   = mux_wdata;
    assign bus.ram_ocea   = 1'b1;
    assign bus.ram_reseta = reset;
    // Data path is shared; the rvalid strobes say whose it is.
    assign bus.rd_data    = bus.ram_douta;

    vram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_vld   (issue_vld),
        .issue_owner (issue_owner),
        .cpu_rvalid  (bus.cpu_rvalid),
        .aux_rvalid  (bus.aux_rvalid)
    );

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;
    import vram_pkg::*;

    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) vif ();

    vram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    // Behavioural port-A BRAM: address register then output register.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q1;
    always @(posedge clk) begin
        if (vif.ram_cea) begin
            if (vif.ram_wrea) ram[vif.ram_ada] <= vif.ram_dina;
            else              ram_q1 <= ram[vif.ram_ada];
        end
        if (vif.ram_ocea) vif.ram_douta <= vif.ram_reseta ? '0 : ram_q1;
    end

    // Scoreboard state
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int            due;
        bit            owner;   // 0 cpu, 1 aux
        logic [DW-1:0] data;
    } ret_t;

    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    int            mdl_denied;
    ret_t          retq[$];

    // Observations for directed checks
    int            cpu_ack_cyc = -1;
    int            cpu_rv_cyc  = -1;
    logic [DW-1:0] cpu_rv_dat  = '0;
    int            cpu_rv_cnt  = 0;
    int            aux_rv_cnt  = 0;
    int            aux_rv_cyc  = -1;
    logic [DW-1:0] aux_seen[$];
    int            aux_seen_cyc[$];
    int            aux_ack_cyc[$];
    int            wrea_cnt    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the arbitration rules.
    always @(negedge clk) begin
        int            win;    // 0 idle, 1 cpu, 2 aux
        logic [AW-1:0] e_ada;
        logic [DW-1:0] e_dina;
        logic          e_we;
        logic          e_crv, e_arv;
        logic [DW-1:0] e_dat;
        ret_t          r;
        cyc++;
        chk("ram_ocea", vif.ram_ocea, 1);
        chk("both_rvalid", vif.cpu_rvalid & vif.aux_rvalid, 0);
        if (reset) begin
            chk("rst_cpu_ack", vif.cpu_ack, 0);
            chk("rst_aux_ack", vif.aux_ack, 0);
            chk("rst_cea", vif.ram_cea, 0);
            chk("rst_wrea", vif.ram_wrea, 0);
            chk("rst_ada", vif.ram_ada, 0);
            chk("rst_dina", vif.ram_dina, 0);
            chk("rst_cpu_rv", vif.cpu_rvalid, 0);
            chk("rst_aux_rv", vif.aux_rvalid, 0);
            chk("rst_reseta", vif.ram_reseta, 1);
            retq.delete();
            mdl_denied = 0;
        end else begin
            chk("reseta", vif.ram_reseta, 0);
            win = 0;
            if (vif.cpu_req && vif.aux_req) win = (mdl_denied >= SMAX) ? 2 : 1;
            else if (vif.cpu_req)            win = 1;
            else if (vif.aux_req)            win = 2;
            e_ada = '0; e_dina = '0; e_we = 1'b0;
            if (win == 1) begin e_ada = vif.cpu_addr; e_dina = vif.cpu_wdata; e_we = vif.cpu_we; end
            if (win == 2) begin e_ada = vif.aux_addr; e_dina = vif.aux_wdata; e_we = vif.aux_we; end
            chk("cpu_ack", vif.cpu_ack, (win == 1) ? 1 : 0);
            chk("aux_ack", vif.aux_ack, (win == 2) ? 1 : 0);
            chk("ram_cea", vif.ram_cea, (win != 0) ? 1 : 0);
            chk("ram_wrea", vif.ram_wrea, e_we);
            chk("ram_ada", vif.ram_ada, e_ada);
            chk("ram_dina", vif.ram_dina, e_dina);

            e_crv = 1'b0; e_arv = 1'b0; e_dat = '0;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                e_dat = r.data;
                if (r.owner) e_arv = 1'b1; else e_crv = 1'b1;
            end
            chk("cpu_rvalid", vif.cpu_rvalid, e_crv);
            chk("aux_rvalid", vif.aux_rvalid, e_arv);
            if (e_crv || e_arv) chk("rd_data", vif.rd_data, e_dat);

            if (win != 0) begin
                if (e_we) mdl_mem[e_ada] = e_dina;
                else begin
                    r.due = cyc + LAT; r.owner = (win == 2); r.data = mdl_mem[e_ada];
                    retq.push_back(r);
                end
            end
            if (!vif.aux_req || win == 2) mdl_denied = 0;
            else if (win == 1)            mdl_denied++;
        end
        if (vif.cpu_ack) cpu_ack_cyc = cyc;
        if (vif.aux_ack) aux_ack_cyc.push_back(cyc);
        if (vif.ram_wrea) wrea_cnt++;
        if (vif.cpu_rvalid) begin cpu_rv_cyc = cyc; cpu_rv_dat = vif.rd_data; cpu_rv_cnt++; end
        if (vif.aux_rvalid) begin
            aux_rv_cyc = cyc; aux_rv_cnt++;
            aux_seen.push_back(vif.rd_data); aux_seen_cyc.push_back(cyc);
        end
    end

    // Drives one access (starting just after a posedge), waits for its ack,
    // returns just after the following posedge with the request still raised.
    task automatic access(input bit is_aux, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        if (is_aux) begin
            vif.aux_req = 1'b1; vif.aux_we = we; vif.aux_addr = a; vif.aux_wdata = d;
        end else begin
            vif.cpu_req = 1'b1; vif.cpu_we = we; vif.cpu_addr = a; vif.cpu_wdata = d;
        end
        while (1) begin
            @(negedge clk);
            if (is_aux ? vif.aux_ack : vif.cpu_ack) break;
            n++;
            if (n > 50) begin
                chk("ack_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] cpu_seq, aux_seq;
        int ack_c, base, snap, first_g;
        reset = 1'b1;
        vif.cpu_req = 0; vif.cpu_we = 0; vif.cpu_addr = '0; vif.cpu_wdata = '0;
        vif.aux_req = 0; vif.aux_we = 0; vif.aux_addr = '0; vif.aux_wdata = '0;
        vif.ram_douta = '0;
        ram_q1 = '0;
        mdl_denied = 0;
        for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; mdl_mem[i] = '0; end
        tick(3);
        reset = 1'b0;
        tick(1);

        // 1: cpu write then read back
        access(0, 1, 15'h1234, 8'hA5);
        vif.cpu_req = 0;
        access(0, 0, 15'h1234, 8'h00);
        ack_c = cpu_ack_cyc;
        vif.cpu_req = 0;
        tick(4);
        chk("t1_rv_latency", cpu_rv_cyc - ack_c, 2);
        chk("t1_rd_data", cpu_rv_dat, 8'hA5);
        chk("t1_aux_rv_none", aux_rv_cnt, 0);

        // 2: both reading continuously -> cpu x4, aux, repeating
        vif.cpu_req = 1; vif.cpu_we = 0; vif.cpu_addr = 15'h0005;
        vif.aux_req = 1; vif.aux_we = 0; vif.aux_addr = 15'h0006;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_seq[i] = vif.cpu_ack;
            aux_seq[i] = vif.aux_ack;
        end
        @(posedge clk); #1;
        vif.cpu_req = 0; vif.aux_req = 0;
        chk("t2_aux_pattern", aux_seq, 10'b10_0001_0000);
        chk("t2_cpu_pattern", cpu_seq, 10'b01_1110_1111);
        tick(4);

        // 3: aux streams reads of 0..3
        for (int i = 0; i < 4; i++) access(1, 1, AW'(i), DW'(8'h40 + i));
        vif.aux_req = 0;
        tick(1);
        aux_seen.delete(); aux_seen_cyc.delete(); aux_ack_cyc.delete();
        for (int i = 0; i < 4; i++) access(1, 0, AW'(i), 8'h00);
        vif.aux_req = 0;
        tick(4);
        chk("t3_ack_span", aux_ack_cyc[3] - aux_ack_cyc[0], 3);
        chk("t3_rv_count", aux_seen.size(), 4);
        chk("t3_rv_span", aux_seen_cyc[3] - aux_seen_cyc[0], 3);
        for (int i = 0; i < 4; i++) chk("t3_rd_order", aux_seen[i], 8'h40 + i);

        // 4: interleaved cpu read 0x10 and aux read 0x20
        access(0, 1, 15'h0010, 8'h11);
        access(0, 1, 15'h0020, 8'h22);
        vif.cpu_req = 0;
        tick(1);
        vif.cpu_req = 1; vif.cpu_we = 0; vif.cpu_addr = 15'h0010;
        vif.aux_req = 1; vif.aux_we = 0; vif.aux_addr = 15'h0020;
        tick(1);
        vif.cpu_req = 0;
        tick(1);
        vif.aux_req = 0;
        tick(4);
        chk("t4_cpu_data", cpu_rv_dat, 8'h11);
        chk("t4_aux_data", aux_seen[aux_seen.size()-1], 8'h22);
        chk("t4_aux_after_cpu", aux_rv_cyc - cpu_rv_cyc, 1);

        // 5: reset one cycle after a cpu read ack, with aux fully starved
        vif.cpu_req = 1; vif.cpu_we = 0; vif.cpu_addr = 15'h0010;
        vif.aux_req = 1; vif.aux_we = 0; vif.aux_addr = 15'h0020;
        tick(4);
        base = cpu_ack_cyc;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        snap = cpu_rv_cnt;
        @(negedge clk);
        chk("t5_first_cpu_ack", vif.cpu_ack, 1);
        chk("t5_first_aux_ack", vif.aux_ack, 0);
        @(posedge clk); #1;
        first_g = cpu_ack_cyc;
        vif.cpu_req = 0; vif.aux_req = 0;
        tick(4);
        chk("t5_grant_after_rst", first_g - base, 2);
        chk("t5_only_new_rv", cpu_rv_cnt - snap, 1);
        chk("t5_new_rv_cycle", cpu_rv_cyc - first_g, 2);

        // 6: aux write 0x7FFF then cpu read 0x7FFF
        snap = wrea_cnt;
        access(1, 1, 15'h7FFF, 8'h3C);
        vif.aux_req = 0;
        access(0, 0, 15'h7FFF, 8'h00);
        vif.cpu_req = 0;
        tick(4);
        chk("t6_wrea_cycles", wrea_cnt - snap, 1);
        chk("t6_rd_data", cpu_rv_dat, 8'h3C);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
